// File: rtl/writeback_arbiter_if.sv
// Writeback bus: ALU result stream, load stream, register-file write port
// and the decode-stage forwarding lookup.
interface writeback_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        EnableWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  fwd_reg;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    input  fwd_reg,
    output alu_ready,
    output EnableWrite, write_reg, write_data,
    output fwd_hit, fwd_data
  );

  // Pipeline / register-file side
  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    output fwd_reg,
    input  alu_ready,
    input  EnableWrite, write_reg, write_data,
    input  fwd_hit, fwd_data
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU results (queued) and load data (never stalled) onto the single
// register-file write port, and reports in-flight values for forwarding.
module writeback_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  writeback_arbiter_if.slave bus
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]    q_reg  [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic          ew_q;
  logic [4:0]    wreg_q;
  logic [31:0]   wdata_q;

  logic          mem_win;
  logic          push;
  logic          pop;

  logic          hit;
  logic [31:0]   hit_data;
  logic [AW-1:0] idx;

  // Readiness comes from the registered count only; a same-cycle pop does not help
  assign bus.alu_ready   = (count < FULL);
  assign mem_win         = bus.mem_valid && (bus.mem_reg != '0);
  assign push            = bus.alu_valid && bus.alu_ready && (bus.alu_reg != '0);
  assign pop             = !mem_win && (count != '0);

  assign bus.EnableWrite = ew_q;
  assign bus.write_reg   = wreg_q;
  assign bus.write_data  = wdata_q;
  assign bus.fwd_hit     = hit;
  assign bus.fwd_data    = hit_data;

  // Queue storage; validity is tracked by count, so no reset is needed here
  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[wr_ptr]  <= bus.alu_reg;
      q_data[wr_ptr] <= bus.alu_data;
    end
  end

  // Pointer/count bookkeeping and write-port selection (loads win over the queue)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ew_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (mem_win) begin
        ew_q    <= 1'b1;
        wreg_q  <= bus.mem_reg;
        wdata_q <= bus.mem_data;
      end else if (pop) begin
        ew_q    <= 1'b1;
        wreg_q  <= q_reg[rd_ptr];
        wdata_q <= q_data[rd_ptr];
      end else begin
        ew_q    <= 1'b0;
      end
    end
  end

  // Forwarding lookup: lowest priority is applied first and overwritten by
  // higher-priority matches (output reg, then queue oldest->youngest, then load)
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    if (ew_q && (wreg_q == bus.fwd_reg)) begin
      hit      = 1'b1;
      hit_data = wdata_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if ((i < 32'(count)) && (q_reg[idx] == bus.fwd_reg)) begin
        hit      = 1'b1;
        hit_data = q_data[idx];
      end
    end
    if (bus.mem_valid && (bus.mem_reg == bus.fwd_reg)) begin
      hit      = 1'b1;
      hit_data = bus.mem_data;
    end
    if (bus.fwd_reg == '0) begin
      hit      = 1'b0;
      hit_data = '0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, latency, load priority,
// full-queue backpressure, x0 suppression and forwarding priority.
module tb_writeback_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [36:0] log_q[$];

  writeback_arbiter_if bus ();

  writeback_arbiter #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Record every register-file write, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.EnableWrite === 1'b1) log_q.push_back({bus.write_reg, bus.write_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_reg   = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_reg   = '0;
    bus.mem_data  = '0;
    bus.fwd_reg   = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #1;
    checks++; if (bus.EnableWrite !== 1'b0) begin errors++; $display("FAIL reset_ew: got %b required 0", bus.EnableWrite); end
    checks++; if (bus.write_reg !== 5'd0) begin errors++; $display("FAIL reset_reg: got %0d required 0", bus.write_reg); end
    checks++; if (bus.write_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h required 0", bus.write_data); end
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", bus.alu_ready); end
    #6 rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    log_q.delete();
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd9; bus.alu_data = 32'h0000000D;
    tick();
    bus.alu_valid = 1'b0;
    checks++; if (bus.EnableWrite !== 1'b0) begin errors++; $display("FAIL single_early: got %b required 0", bus.EnableWrite); end
    tick();
    checks++; if (bus.EnableWrite !== 1'b1) begin errors++; $display("FAIL single_ew: got %b required 1", bus.EnableWrite); end
    checks++; if (bus.write_reg !== 5'd9) begin errors++; $display("FAIL single_reg: got %0d required 9", bus.write_reg); end
    checks++; if (bus.write_data !== 32'hD) begin errors++; $display("FAIL single_data: got %h required d", bus.write_data); end
    tick();
    checks++; if (bus.EnableWrite !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b required 0", bus.EnableWrite); end
    checks++; if (bus.write_reg !== 5'd9) begin errors++; $display("FAIL single_hold: got %0d required 9", bus.write_reg); end
    tick();
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d required 1", log_q.size()); end
  endtask

  task automatic test_mem_priority();
    logic [36:0] exp_q[$];
    log_q.delete();
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'h11;
    tick();
    bus.alu_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.mem_valid = 1'b1; bus.mem_reg = 5'(6 + k); bus.mem_data = 32'(32'h60 + k);
      tick();
      if (k == 0) begin
        checks++; if (bus.EnableWrite !== 1'b1 || bus.write_reg !== 5'd6) begin
          errors++; $display("FAIL mem_latency: got ew=%b reg=%0d required ew=1 reg=6", bus.EnableWrite, bus.write_reg);
        end
      end
    end
    bus.mem_valid = 1'b0;
    repeat (3) tick();
    exp_q = '{{5'd6, 32'h60}, {5'd7, 32'h61}, {5'd8, 32'h62}, {5'd5, 32'h11}};
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL mem_order_count: got %0d required 4", log_q.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (log_q[k] !== exp_q[k]) begin errors++; $display("FAIL mem_order[%0d]: got %h required %h", k, log_q[k], exp_q[k]); end
    end
    // mem_valid with x0 destination must not block the queue
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'h22;
    tick();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd0; bus.mem_data = 32'hBAD;
    tick();
    bus.mem_valid = 1'b0;
    checks++; if (bus.EnableWrite !== 1'b1 || bus.write_reg !== 5'd5 || bus.write_data !== 32'h22) begin
      errors++; $display("FAIL mem_x0_drain: got ew=%b reg=%0d data=%h required ew=1 reg=5 data=22", bus.EnableWrite, bus.write_reg, bus.write_data);
    end
    tick();
  endtask

  task automatic test_full();
    logic [36:0] seen_q[$];
    logic [36:0] expv;
    int          ready_drops;
    log_q.delete();
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd1; bus.mem_data = 32'h100;
    for (int k = 0; k < 4; k++) begin
      bus.alu_valid = 1'b1; bus.alu_reg = 5'(10 + k); bus.alu_data = 32'(32'hA0 + k);
      checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL full_ready[%0d]: got %b required 1", k, bus.alu_ready); end
      tick();
    end
    checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL full_drop: got %b required 0", bus.alu_ready); end
    bus.alu_reg = 5'd14; bus.alu_data = 32'hA4;
    tick();
    tick();
    checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL full_held: got %b required 0", bus.alu_ready); end
    bus.mem_valid = 1'b0;
    tick();
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL full_reopen: got %b required 1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    repeat (8) tick();
    foreach (log_q[i]) if (log_q[i][36:32] != 5'd1) seen_q.push_back(log_q[i]);
    checks++; if (seen_q.size() != 5) begin errors++; $display("FAIL full_count: got %0d required 5", seen_q.size()); end
    for (int k = 0; k < 5; k++) begin
      expv = {5'(10 + k), 32'(32'hA0 + k)};
      checks++; if (seen_q[k] !== expv) begin errors++; $display("FAIL full_order[%0d]: got %h required %h", k, seen_q[k], expv); end
    end
    // Ten more pushes, streaming through the wrapped pointers
    log_q.delete();
    ready_drops = 0;
    for (int k = 0; k < 10; k++) begin
      bus.alu_valid = 1'b1; bus.alu_reg = 5'(20 + k); bus.alu_data = 32'(32'h1000 + k);
      if (bus.alu_ready !== 1'b1) ready_drops++;
      tick();
    end
    bus.alu_valid = 1'b0;
    repeat (4) tick();
    checks++; if (ready_drops != 0) begin errors++; $display("FAIL wrap_ready: got %0d stalls required 0", ready_drops); end
    checks++; if (log_q.size() != 10) begin errors++; $display("FAIL wrap_count: got %0d required 10", log_q.size()); end
    for (int k = 0; k < 10; k++) begin
      expv = {5'(20 + k), 32'(32'h1000 + k)};
      checks++; if (log_q[k] !== expv) begin errors++; $display("FAIL wrap_order[%0d]: got %h required %h", k, log_q[k], expv); end
    end
  endtask

  task automatic test_x0();
    log_q.delete();
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'hDEAD;
    tick();
    bus.alu_valid = 1'b0;
    repeat (3) tick();
    checks++; if (log_q.size() != 0) begin errors++; $display("FAIL x0_enqueue: got %0d writes required 0", log_q.size()); end
    bus.fwd_reg = 5'd0; bus.mem_valid = 1'b1; bus.mem_reg = 5'd0; bus.mem_data = 32'h5;
    #1;
    checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'd0) begin
      errors++; $display("FAIL x0_fwd: got hit=%b data=%h required hit=0 data=0", bus.fwd_hit, bus.fwd_data);
    end
    bus.mem_valid = 1'b0;
    tick();
  endtask

  task automatic test_fwd_priority();
    bus.fwd_reg = 5'd18;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd18; bus.alu_data = 32'hFFFFFFF1;
    tick();
    checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'hFFFFFFF1) begin
      errors++; $display("FAIL fwd_queue: got hit=%b data=%h required hit=1 data=fffffff1", bus.fwd_hit, bus.fwd_data);
    end
    bus.alu_data = 32'h4;
    tick();
    bus.alu_valid = 1'b0;
    #1;
    checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h4) begin
      errors++; $display("FAIL fwd_youngest: got hit=%b data=%h required hit=1 data=4", bus.fwd_hit, bus.fwd_data);
    end
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd18; bus.mem_data = 32'h99;
    #1;
    checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h99) begin
      errors++; $display("FAIL fwd_mem: got hit=%b data=%h required hit=1 data=99", bus.fwd_hit, bus.fwd_data);
    end
    bus.mem_valid = 1'b0; bus.mem_reg = 5'd0; bus.mem_data = 32'h0;
    tick();
    checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h4) begin
      errors++; $display("FAIL fwd_outreg: got hit=%b data=%h required hit=1 data=4", bus.fwd_hit, bus.fwd_data);
    end
    tick();
    checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'd0) begin
      errors++; $display("FAIL fwd_gone: got hit=%b data=%h required hit=0 data=0", bus.fwd_hit, bus.fwd_data);
    end
    bus.fwd_reg = 5'd0;
  endtask

  task automatic test_reset_mid();
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd1; bus.mem_data = 32'h100;
    for (int k = 0; k < 3; k++) begin
      bus.alu_valid = 1'b1; bus.alu_reg = 5'(2 + k); bus.alu_data = 32'(32'h200 + k);
      tick();
    end
    #3;
    idle();
    bus.fwd_reg = 5'd2;
    rst = 1'b1;
    #1;
    checks++; if (bus.EnableWrite !== 1'b0 || bus.write_reg !== 5'd0 || bus.write_data !== 32'd0) begin
      errors++; $display("FAIL midrst_out: got ew=%b reg=%0d data=%h required all 0", bus.EnableWrite, bus.write_reg, bus.write_data);
    end
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b required 1", bus.alu_ready); end
    checks++; if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL midrst_fwd: got %b required 0", bus.fwd_hit); end
    @(posedge clk);
    #3 rst = 1'b0;
    log_q.delete();
    repeat (5) tick();
    checks++; if (log_q.size() != 0) begin errors++; $display("FAIL midrst_nowrite: got %0d writes required 0", log_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mem_priority();
    test_full();
    test_x0();
    test_fwd_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges the pipeline's two result streams (ALU results and memory load data) onto the register file's single write port (`EnableWrite`, `write_reg`, `write_data`). ALU results queue in a small FIFO. Memory writes always take the port immediately because loads cannot be stalled. A lookup port reports any result still in flight for a given register so the decode stage can forward or stall.

## Interface
- `DEPTH`, 4: ALU pending FIFO entries (power of two, ≥2).
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU result offered this cycle.
- `alu_ready`  out  1  FIFO can accept; transfer when `alu_valid && alu_ready`.
- `alu_reg`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `mem_valid`  in  1  load result present; never stalled.
- `mem_reg`  in  5  load destination register.
- `mem_data`  in  32  load data.
- `EnableWrite`  out  1  register-file write enable (registered).
- `write_reg`  out  5  register-file write address (registered).
- `write_data`  out  32  register-file write data (registered).
- `fwd_reg`  in  5  register queried by decode.
- `fwd_hit`  out  1  a write to `fwd_reg` is in flight (combinational).
- `fwd_data`  out  32  newest in-flight value for `fwd_reg`.

## Operation
- FIFO: circular buffer with read pointer, write pointer and count (0..`DEPTH`).
- `alu_ready` = (count < `DEPTH`), computed from the registered count only. A pop in the same cycle does not raise it.
- Push: on an ALU handshake with `alu_reg != 0`, write the entry at the write pointer.
- `alu_reg == 0`: the handshake completes but nothing is enqueued (x0 is hardwired zero).
- Port selection each cycle, from the inputs and state at the posedge:
  - If `mem_valid && mem_reg != 0`: the outputs load `{1, mem_reg, mem_data}` and the FIFO does not pop.
  - Otherwise, if count > 0: pop the head; the outputs load `{1, head.reg, head.data}`.
  - Otherwise: `EnableWrite` ← 0. `write_reg` and `write_data` keep their last values.
- `mem_valid` with `mem_reg == 0` is ignored and does not block a FIFO pop.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Push into an empty FIFO: the entry cannot pop in that same cycle. It becomes the head on the next cycle.
- Pointers wrap modulo `DEPTH`.
- Ordering:
  - Within the ALU stream, writes occur in acceptance order.
  - Ordering between the mem and ALU streams to the same register is the issuer's responsibility.
- Forwarding search for `fwd_reg`, highest priority first:
  1. `mem_valid && mem_reg == fwd_reg`.
  2. FIFO entries, youngest to oldest.
  3. Registered output, when `EnableWrite && write_reg == fwd_reg`.
  - The first match drives `fwd_hit = 1` and `fwd_data`.
- `fwd_reg == 0`: `fwd_hit = 0` and `fwd_data = 0`.
- No match: `fwd_hit = 0` and `fwd_data = 0`.

## Timing
- Reset (asynchronous, immediate):
  - `EnableWrite` = 0, `write_reg` = 0, `write_data` = 0.
  - count = 0, both pointers = 0, so `alu_ready` = 1 and `fwd_hit` = 0 (absent a mem match).
- Reset mid-operation discards all queued entries. No partial write is emitted.
- Mem latency: `mem_valid` at edge N → `EnableWrite` high during cycle N+1.
- ALU latency, idle port: accepted at edge N → at head after edge N → written out at edge N+1 → `EnableWrite` high during N+2.
- Each queued ALU entry waits one extra cycle for every mem write that wins the port.
- `EnableWrite` is a one-cycle pulse per write. Back-to-back writes keep it high on consecutive cycles.
- The register file samples the outputs on its next clock edge.
- `fwd_hit` and `fwd_data` are combinational from the current state and the `mem_*` and `fwd_reg` inputs. There is no added cycle.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle with 3 entries queued → outputs zero immediately, `alu_ready` = 1. After release, no `EnableWrite` pulse occurs.
- **Single ALU write:** ALU write `r9 = 0x0000000D` on an idle port → `EnableWrite` = 1, `write_reg` = 9, `write_data` = 0xD two cycles after acceptance, for exactly one cycle.
- **Mem priority:**
  - Queue ALU `r5 = 0x11`, then drive `mem_valid` on 3 consecutive cycles (`r6`, `r7`, `r8`) → writes appear in order 6, 7, 8, 5.
  - `mem_reg = 0` with `mem_valid = 1` → r5 drains without delay.
- **Full FIFO:** hold `mem_valid` (nonzero reg) and push 5 ALU results with `DEPTH` = 4 → `alu_ready` drops after the 4th. The 5th is held until `mem_valid` falls. All 5 are written in order with no loss or duplicate. Pointers wrap correctly across 10 further pushes.
- **x0 suppression:**
  - ALU handshake with `alu_reg = 0` → no enqueue, no `EnableWrite`.
  - `fwd_reg = 0` → `fwd_hit` = 0.
- **Forwarding priority:** queue `r18 = 0xFFFFFFF1`, then `r18 = 0x4`, with `mem_valid` idle → `fwd_reg = 18` gives hit with 0x4. Assert `mem_valid` with `mem_reg = 18`, `mem_data = 0x99` → 0x99. After both FIFO entries drain → hit only while the last write is on the output register, then `fwd_hit` = 0.
